// File: rtl/fmap_raster_streamer.sv
// fmap_raster_streamer: reads an int8 feature map from 1-cycle-latency SRAM
// and streams it in raster order over valid/ready, through a 2-entry FIFO
// that absorbs the read latency and downstream backpressure.
// Optional build macro FMAP_STREAM_SIDEBAND_EN adds sof/eol/eof outputs that
// travel through the FIFO alongside each pixel.
//
// state | meaning
// IDLE  | waiting for start; zero-sized frames pulse done without reading
// RUN   | issuing SRAM reads whenever the FIFO can absorb the result
// DRAIN | all reads issued; waiting for the last pixel to be accepted
module fmap_raster_streamer #(
    parameter int ADDR_W     = 16,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [7:0]          img_width,
    input  logic [7:0]          img_height,
    output logic                mem_rd_en,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic signed [7:0]   mem_rd_data,
    output logic                valid_out,
    input  logic                ready_in,
    output logic signed [7:0]   data_out,
    output logic                busy,
    output logic                done
`ifdef FMAP_STREAM_SIDEBAND_EN
    ,
    output logic                sof,
    output logic                eol,
    output logic                eof
`endif
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
`ifdef FMAP_STREAM_SIDEBAND_EN
    localparam int ENT_W = 11;
`else
    localparam int ENT_W = 8;
`endif

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t             state;
    logic [ADDR_W-1:0]  base_r;
    logic [15:0]        total_r;
    logic [15:0]        idx;
    logic               rd_pending;
    logic [ENT_W-1:0]   fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   fifo_cnt;
    logic [ENT_W-1:0]   push_ent;
    logic [ENT_W-1:0]   head;
    logic               pop;
    logic               room_ok;
    logic               last_issue;
    logic               dims_ok;
    logic               drain_done;

    assign valid_out  = (fifo_cnt != '0);
    assign pop        = valid_out & ready_in;
    // Occupancy after this cycle (FIFO + landing read - pop) must leave room
    // for one more read; written as a sum compare to avoid underflow.
    assign room_ok    = ({1'b0, fifo_cnt} + {{CNT_W{1'b0}}, rd_pending})
                        <= ({{CNT_W{1'b0}}, 1'b1} + {{CNT_W{1'b0}}, pop});
    assign mem_rd_en  = (state == RUN) && room_ok && !abort;
    assign mem_addr   = base_r + ADDR_W'(idx);
    assign last_issue = (idx == total_r - 16'd1);
    assign dims_ok    = (img_width != 8'd0) && (img_height != 8'd0);
    assign drain_done = !rd_pending && (fifo_cnt == {{(CNT_W-1){1'b0}}, pop});
    assign head       = fifo_mem[rd_ptr];
    assign data_out   = head[7:0];

    // Frame sequencing: latch geometry, walk the read index, raise done/busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            base_r     <= '0;
            total_r    <= '0;
            idx        <= '0;
            rd_pending <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else if (abort) begin
            state      <= IDLE;
            rd_pending <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done       <= 1'b0;
            rd_pending <= mem_rd_en;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (dims_ok) begin
                            base_r  <= base_addr;
                            total_r <= 16'(img_width) * 16'(img_height);
                            idx     <= '0;
                            busy    <= 1'b1;
                            state   <= RUN;
                        end else begin
                            done    <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (mem_rd_en) begin
                        idx <= idx + 16'd1;
                        if (last_issue) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_done) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Output FIFO: read data lands the cycle after the strobe; abort flushes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
        end else if (abort) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (rd_pending) begin
                fifo_mem[wr_ptr] <= push_ent;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (rd_pending && !pop) begin
                fifo_cnt <= fifo_cnt + CNT_W'(1);
            end else if (!rd_pending && pop) begin
                fifo_cnt <= fifo_cnt - CNT_W'(1);
            end
        end
    end

`ifdef FMAP_STREAM_SIDEBAND_EN
    logic [7:0] w_r;
    logic [7:0] col;
    logic [2:0] side_now;
    logic [2:0] side_pend;

    assign side_now = {idx == 16'd0, col == w_r - 8'd1, last_issue};

    // Position flags are computed at read issue and follow the data one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_r       <= '0;
            col       <= '0;
            side_pend <= '0;
        end else begin
            if (state == IDLE && start && !abort) begin
                w_r <= img_width;
                col <= '0;
            end else if (mem_rd_en) begin
                col <= (col == w_r - 8'd1) ? 8'd0 : col + 8'd1;
            end
            if (mem_rd_en) begin
                side_pend <= side_now;
            end
        end
    end

    assign push_ent        = {side_pend, mem_rd_data};
    assign {sof, eol, eof} = head[10:8];
`else
    assign push_ent = mem_rd_data;
`endif

endmodule
